// File: rtl/spi_slave_reg_ctrl_if.sv
// Word/register-bus bundle between the SPI datapath, the transaction controller and the register file.
// master = controller side, slave = datapath plus register file side.
interface spi_slave_reg_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic                  reg_we;
    logic                  reg_rd;
    logic [DATA_WIDTH-1:0] reg_rdata;

    modport master (
        input  rx_data, rx_valid, reg_rdata,
        output tx_data, tx_load, reg_addr, reg_wdata, reg_we, reg_rd
    );

    modport slave (
        output rx_data, rx_valid, reg_rdata,
        input  tx_data, tx_load, reg_addr, reg_wdata, reg_we, reg_rd
    );
endinterface

// File: rtl/spi_slave_reg_ctrl.sv
// SPI command/address/data transaction controller driving a register bus; one frame per cs_n-low period.
// Optional macro SPI_CTRL_BURST_EN enables auto-increment bursts; otherwise one access per frame.
module spi_slave_reg_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_REGS   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs_n,
    spi_slave_reg_ctrl_if.master bus,
    output logic                 busy,
    output logic                 err
);
    typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   NREGS = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_REGS - 1);

`ifdef SPI_CTRL_BURST_EN
    localparam state_t RD_NEXT = READ;
    localparam state_t WR_NEXT = WRITE;
`else
    localparam state_t RD_NEXT = DONE;
    localparam state_t WR_NEXT = DONE;
`endif

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    // Only the last implemented register wraps; out-of-range addresses roll over the full field.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        if (a == LAST)
            return '0;
        return a + ADDR_WIDTH'(1);
    endfunction

    state_t                state, state_next;
    logic                  cs_p0, cs_p1, cs_p2;
    logic                  cs_fall;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  do_wr, do_rd, cmd_wr, frame_start;
    logic                  rd_pend_p1;

    logic [DATA_WIDTH-1:0] tx_data, reg_wdata;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic                  tx_load, reg_we, reg_rd;

    assign cs_fall       = cs_p2 & ~cs_p1;
    assign busy          = (state != IDLE);
    assign bus.tx_data   = tx_data;
    assign bus.tx_load   = tx_load;
    assign bus.reg_addr  = reg_addr;
    assign bus.reg_wdata = reg_wdata;
    assign bus.reg_we    = reg_we;
    assign bus.reg_rd    = reg_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        do_wr       = 1'b0;
        do_rd       = 1'b0;
        cmd_wr      = 1'b0;
        frame_start = 1'b0;
        acc_addr    = addr;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next  = CMD;
                    frame_start = 1'b1;
                end
            end
            CMD: begin
                if (bus.rx_valid) begin
                    acc_addr = bus.rx_data[ADDR_WIDTH-1:0];
                    if (bus.rx_data[DATA_WIDTH-1]) begin
                        do_rd      = 1'b1;
                        state_next = RD_NEXT;
                    end else begin
                        cmd_wr     = 1'b1;
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (bus.rx_valid) begin
                    do_wr      = 1'b1;
                    state_next = WR_NEXT;
                end
            end
            READ: begin
                if (bus.rx_valid)
                    do_rd = 1'b1;
            end
            default: ;
        endcase
        // A word arriving with the cs_n rise is still decoded above; only the state is overridden.
        if (state != IDLE && cs_p1)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_p0      <= 1'b0;
            cs_p1      <= 1'b0;
            cs_p2      <= 1'b0;
            addr       <= '0;
            rd_pend_p1 <= 1'b0;
            tx_data    <= '0;
            tx_load    <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_rd     <= 1'b0;
            err        <= 1'b0;
        end else begin
            // stage p0/p1: cs_n synchronizer, p2 kept for edge detection
            cs_p0 <= cs_n;
            cs_p1 <= cs_p0;
            cs_p2 <= cs_p1;

            // stage p1: register-bus strobes one clk after the triggering word
            reg_we     <= do_wr & in_range(acc_addr);
            reg_rd     <= do_rd & in_range(acc_addr);
            rd_pend_p1 <= do_rd;
            if (do_wr | do_rd) begin
                reg_addr <= acc_addr;
                addr     <= next_addr(acc_addr);
            end else if (cmd_wr) begin
                addr <= acc_addr;
            end
            if (do_wr)
                reg_wdata <= bus.rx_data;

            // stage p2: capture read data (zero for an unimplemented address) and hand it to the datapath
            tx_load <= rd_pend_p1;
            if (rd_pend_p1)
                tx_data <= reg_rd ? bus.reg_rdata : '0;

            if (frame_start)
                err <= 1'b0;
            else if ((do_wr | do_rd) && !in_range(acc_addr))
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Randomized self-checking bench for spi_slave_reg_ctrl against a frame-level reference model.
// Follows SPI_CTRL_BURST_EN the same way as the design build.
module tb_spi_slave_reg_ctrl;
`ifdef SPI_CTRL_BURST_EN
    localparam int BURST = 1;
`else
    localparam int BURST = 0;
`endif

    typedef struct { logic [6:0] a; logic [7:0] d; int c; } wev_t;
    typedef struct { logic [7:0] d; int c; } lev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n = 1'b1;
    logic busy, err;

    spi_slave_reg_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) bus();

    spi_slave_reg_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .NUM_REGS(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cs_n (cs_n),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int viol = 0;

    logic [7:0] mem [16];
    logic [7:0] mem_m [16];
    bit preload = 1'b0;

    wev_t obs_w[$], exp_w[$];
    lev_t obs_l[$], exp_l[$];
    int   rx_cyc[$];
    logic [7:0] fb[$];
    bit   exp_err;

    always @(posedge clk) begin
        cyc++;
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 17);
        end else if (bus.reg_we && bus.reg_addr < 7'd16) begin
            mem[bus.reg_addr[3:0]] <= bus.reg_wdata;
        end
    end
    assign bus.reg_rdata = mem[bus.reg_addr[3:0]];

    bit we_q = 0, rd_q = 0, ld_q = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid) rx_cyc.push_back(cyc);
            if (bus.reg_we) obs_w.push_back('{bus.reg_addr, bus.reg_wdata, cyc});
            if (bus.tx_load) obs_l.push_back('{bus.tx_data, cyc});
            if (bus.reg_we && bus.reg_rd) viol++;
            if ((bus.reg_we && we_q) || (bus.reg_rd && rd_q) || (bus.tx_load && ld_q)) viol++;
        end
        we_q = bus.reg_we;
        rd_q = bus.reg_rd;
        ld_q = bus.tx_load;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_preload();
        preload = 1'b1;
        tick();
        preload = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'(i * 17);
    endtask

    // Frame-level model: which words produce accesses, which addresses, and what data
    task automatic model_frame();
        logic [6:0] a;
        bit rd, ok;
        int n;
        exp_w.delete();
        exp_l.delete();
        exp_err = 0;
        rd = fb[0][7];
        a  = fb[0][6:0];
        if (rd) n = BURST ? fb.size() : 1;
        else    n = BURST ? fb.size() - 1 : (fb.size() > 1 ? 1 : 0);
        for (int k = 0; k < n; k++) begin
            ok = (a < 7'd16);
            if (!ok) exp_err = 1;
            if (rd) begin
                exp_l.push_back('{ok ? mem_m[a[3:0]] : 8'h00, k});
            end else if (ok) begin
                exp_w.push_back('{a, fb[k+1], k + 1});
                mem_m[a[3:0]] = fb[k+1];
            end
            a = ok ? 7'((int'(a) + 1) % 16) : a + 7'd1;
        end
    endtask

    task automatic run_frame(input string name, input int gap);
        int w0, l0, r0;
        model_frame();
        w0 = obs_w.size();
        l0 = obs_l.size();
        r0 = rx_cyc.size();
        cs_n = 1'b0;
        repeat (4) tick();
        foreach (fb[i]) begin
            bus.rx_data  = fb[i];
            bus.rx_valid = 1'b1;
            tick();
            bus.rx_valid = 1'b0;
            repeat (gap - 1) tick();
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_frame: got %b want 1", name, busy);
        end
        cs_n = 1'b1;
        repeat (5) tick();

        checks++;
        if (obs_w.size() - w0 != exp_w.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d want %0d", name, obs_w.size() - w0, exp_w.size());
        end else begin
            foreach (exp_w[i]) begin
                checks++;
                if (obs_w[w0+i].a !== exp_w[i].a || obs_w[w0+i].d !== exp_w[i].d ||
                    obs_w[w0+i].c !== rx_cyc[r0+exp_w[i].c] + 1) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got a=%0d d=%h cyc=%0d want a=%0d d=%h cyc=%0d", name, i,
                             obs_w[w0+i].a, obs_w[w0+i].d, obs_w[w0+i].c,
                             exp_w[i].a, exp_w[i].d, rx_cyc[r0+exp_w[i].c] + 1);
                end
            end
        end
        checks++;
        if (obs_l.size() - l0 != exp_l.size()) begin
            errors++;
            $display("FAIL %s load_count: got %0d want %0d", name, obs_l.size() - l0, exp_l.size());
        end else begin
            foreach (exp_l[i]) begin
                checks++;
                if (obs_l[l0+i].d !== exp_l[i].d || obs_l[l0+i].c !== rx_cyc[r0+exp_l[i].c] + 2) begin
                    errors++;
                    $display("FAIL %s load[%0d]: got d=%h cyc=%0d want d=%h cyc=%0d", name, i,
                             obs_l[l0+i].d, obs_l[l0+i].c, exp_l[i].d, rx_cyc[r0+exp_l[i].c] + 2);
                end
            end
        end
        checks++;
        if (err !== exp_err || busy !== 1'b0 || viol !== 0) begin
            errors++;
            $display("FAIL %s end_state: got err=%b busy=%b viol=%0d want err=%b busy=0 viol=0",
                     name, err, busy, viol, exp_err);
        end
    endtask

    task automatic test_reset();
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.tx_data, bus.tx_load, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_rd, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tx=%h ld=%b a=%h wd=%h we=%b rd=%b busy=%b err=%b want all 0",
                     bus.tx_data, bus.tx_load, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_rd, busy, err);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        do_preload();
    endtask

    task automatic test_write_burst();
        logic [6:0] ta [2] = '{7'd3, 7'd4};
        logic [7:0] td [2] = '{8'hA5, 8'h5A};
        int w0 = obs_w.size();
        fb = '{8'h03, 8'hA5, 8'h5A};
        run_frame("write_burst", 3);
        checks++;
        if (obs_w.size() - w0 != (BURST ? 2 : 1) || err !== 1'b0) begin
            errors++;
            $display("FAIL write_burst_spec: got writes=%0d err=%b want writes=%0d err=0",
                     obs_w.size() - w0, err, BURST ? 2 : 1);
        end
        for (int i = 0; i < obs_w.size() - w0 && i < 2; i++) begin
            checks++;
            if (obs_w[w0+i].a !== ta[i] || obs_w[w0+i].d !== td[i]) begin
                errors++;
                $display("FAIL write_burst_word%0d: got a=%0d d=%h want a=%0d d=%h",
                         i, obs_w[w0+i].a, obs_w[w0+i].d, ta[i], td[i]);
            end
        end
    endtask

    task automatic test_read_wrap();
        logic [7:0] td [3] = '{8'hEE, 8'hFF, 8'h00};
        int l0;
        do_preload();
        l0 = obs_l.size();
        fb = '{8'h8E, 8'h00, 8'h00};
        run_frame("read_wrap", 3);
        checks++;
        if (obs_l.size() - l0 != (BURST ? 3 : 1)) begin
            errors++;
            $display("FAIL read_wrap_count: got %0d want %0d", obs_l.size() - l0, BURST ? 3 : 1);
        end
        for (int i = 0; i < obs_l.size() - l0 && i < 3; i++) begin
            checks++;
            if (obs_l[l0+i].d !== td[i]) begin
                errors++;
                $display("FAIL read_wrap_word%0d: got %h want %h", i, obs_l[l0+i].d, td[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        fb = '{8'h20, 8'h77};
        run_frame("out_of_range", 3);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_sticky: got %b want 1", err);
        end
        cs_n = 1'b0;
        repeat (4) tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_clear: got err=%b busy=%b want err=0 busy=1", err, busy);
        end
        cs_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_cs_rise_same_cycle();
        int l0;
        cs_n = 1'b0;
        repeat (4) tick();
        bus.rx_data  = 8'h05;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        repeat (2) tick();
        cs_n = 1'b1;
        repeat (2) tick();
        bus.rx_data  = 8'h3C;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        checks++;
        if (bus.reg_we !== 1'b1 || bus.reg_addr !== 7'd5 || bus.reg_wdata !== 8'h3C || busy !== 1'b0) begin
            errors++;
            $display("FAIL cs_rise_write: got we=%b a=%0d d=%h busy=%b want we=1 a=5 d=3c busy=0",
                     bus.reg_we, bus.reg_addr, bus.reg_wdata, busy);
        end
        mem_m[5] = 8'h3C;
        repeat (4) tick();
        l0 = obs_l.size();
        fb = '{8'h85};
        run_frame("cs_rise_fresh_cmd", 3);
        checks++;
        if (obs_l.size() - l0 != 1 || obs_l[obs_l.size()-1].d !== 8'h3C) begin
            errors++;
            $display("FAIL cs_rise_readback: got n=%0d d=%h want n=1 d=3c",
                     obs_l.size() - l0, obs_l[obs_l.size()-1].d);
        end
    endtask

    task automatic test_single_access();
        logic [6:0] ta [2] = '{7'd1, 7'd2};
        logic [7:0] td [2] = '{8'h11, 8'h22};
        int w0 = obs_w.size();
        fb = '{8'h01, 8'h11, 8'h22};
        run_frame("single_access", 3);
        checks++;
        if (obs_w.size() - w0 != (BURST ? 2 : 1)) begin
            errors++;
            $display("FAIL single_access_count: got %0d want %0d", obs_w.size() - w0, BURST ? 2 : 1);
        end
        for (int i = 0; i < obs_w.size() - w0 && i < 2; i++) begin
            checks++;
            if (obs_w[w0+i].a !== ta[i] || obs_w[w0+i].d !== td[i]) begin
                errors++;
                $display("FAIL single_access_word%0d: got a=%0d d=%h want a=%0d d=%h",
                         i, obs_w[w0+i].a, obs_w[w0+i].d, ta[i], td[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        fb = '{8'h0C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_frame("b2b_write", 2);
        fb = '{8'h8C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("b2b_read", 2);
    endtask

    task automatic test_random();
        int len;
        logic [6:0] a;
        for (int f = 0; f < 24; f++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(16, 127)) : 7'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) a = 7'($urandom_range(124, 127));
            fb.delete();
            fb.push_back({1'($urandom_range(0, 1)), a});
            len = $urandom_range(0, 5);
            for (int k = 0; k < len; k++) fb.push_back(8'($urandom));
            run_frame($sformatf("random%0d", f), $urandom_range(2, 3));
        end
    endtask

    task automatic test_reset_mid_write();
        int w0;
        cs_n = 1'b0;
        repeat (4) tick();
        bus.rx_data  = 8'h02;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        repeat (2) tick();
        bus.rx_data  = 8'h99;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        checks++;
        if (bus.reg_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre_we: got %b want 1", bus.reg_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.tx_data, bus.tx_load, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_rd, busy, err} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got tx=%h ld=%b a=%h wd=%h we=%b rd=%b busy=%b err=%b want all 0",
                     bus.tx_data, bus.tx_load, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_rd, busy, err);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        w0 = obs_w.size();
        bus.rx_data  = 8'h44;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (obs_w.size() != w0 || busy !== 1'b0 || mem[2] !== mem_m[2]) begin
            errors++;
            $display("FAIL rst_mid_no_resume: got writes=%0d busy=%b mem2=%h want writes=0 busy=0 mem2=%h",
                     obs_w.size() - w0, busy, mem[2], mem_m[2]);
        end
        cs_n = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_wrap();
        test_out_of_range();
        test_cs_rise_same_cycle();
        test_single_access();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
